// File: rtl/led_pkg.sv
// led_pkg: shared mode encoding and counter-width helper for the LED blocks
package led_pkg;
  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_MARQUEE = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronise, debounce and edge-detect a raw push-button
module btn_debounce
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_rise
);
  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_btn};
      r_level_d <= r_level;
      if (r_sync[1] == r_level) r_cnt <= '0;
      else if (r_cnt == CNT_MAX) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_rise = r_level & ~r_level_d;
endmodule

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: LED bank sequencer with marquee, blink and breathe patterns
module led_mode_ctrl
  import led_pkg::*;
#(
  parameter int NUM_LEDS        = 4,
  parameter int STEP_CYCLES     = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int PWM_BITS        = 8,
  parameter int BREATH_DIV      = 390_625
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_mode,
  input  logic                enable,
  output logic [NUM_LEDS-1:0] leds,
  output logic [1:0]          mode,
  output logic                step_tick
);
  localparam int PW = cnt_w(STEP_CYCLES);
  localparam int BW = cnt_w(BREATH_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(STEP_CYCLES - 1);
  localparam logic [BW-1:0] BDIV_MAX = BW'(BREATH_DIV - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  mode_t               r_mode;
  mode_t               w_mode_nxt;
  logic                w_adv;
  logic                w_run;
  logic                w_step;
  logic                w_br;
  logic                w_bterm;
  logic                w_flip;
  logic [NUM_LEDS-1:0] w_leds_nxt;
  logic [PW-1:0]       r_pre;
  logic [BW-1:0]       r_bdiv;
  logic [NUM_LEDS-1:0] r_pat;
  logic [NUM_LEDS-1:0] r_leds;
  logic [PWM_BITS-1:0] r_pwm;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_dir;
  logic                r_phase;
  logic                r_tick;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (btn_mode),
    .o_rise (w_adv)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_mode <= MODE_MARQUEE;
    else r_mode <= w_mode_nxt;
  end
  always_comb begin
    w_mode_nxt = w_adv ? mode_t'(r_mode + 2'd1) : r_mode;
    w_run      = enable && (r_mode != MODE_OFF);
    w_step     = w_run && (r_pre == PRE_MAX);
    w_br       = enable && (r_mode == MODE_BREATHE);
    w_bterm    = r_bdiv == BDIV_MAX;
    w_flip     = r_dir ? (r_duty == '0) : (r_duty == DUTY_MAX);
    w_leds_nxt = !enable                   ? '0 :
                 r_mode == MODE_MARQUEE    ? r_pat :
                 r_mode == MODE_BLINK      ? {NUM_LEDS{r_phase}} :
                 r_mode == MODE_BREATHE    ? {NUM_LEDS{r_pwm < r_duty}} : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_leds  <= '0;
      r_tick  <= 1'b0;
      r_pre   <= '0;
      r_pat   <= NUM_LEDS'(1);
      r_phase <= 1'b0;
      r_duty  <= '0;
      r_dir   <= 1'b0;
      r_pwm   <= '0;
      r_bdiv  <= '0;
    end else begin
      r_leds <= w_leds_nxt;
      r_tick <= w_step && !w_adv;
      if (w_adv) begin
        r_pre   <= '0;
        r_pat   <= NUM_LEDS'(1);
        r_phase <= 1'b0;
        r_duty  <= '0;
        r_dir   <= 1'b0;
        r_pwm   <= '0;
        r_bdiv  <= '0;
      end else begin
        if (w_run) r_pre <= w_step ? '0 : r_pre + 1'b1;
        if (w_step) begin
          r_pat   <= {r_pat[NUM_LEDS-2:0], r_pat[NUM_LEDS-1]};
          r_phase <= ~r_phase;
        end
        if (w_br) begin
          r_pwm  <= r_pwm + 1'b1;
          r_bdiv <= w_bterm ? '0 : r_bdiv + 1'b1;
          if (w_bterm) begin
            r_dir  <= r_dir ^ w_flip;
            r_duty <= (r_dir ^ w_flip) ? r_duty - 1'b1 : r_duty + 1'b1;
          end
        end
      end
    end
  end
  assign leds      = r_leds;
  assign mode      = r_mode;
  assign step_tick = r_tick;
endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb_led_mode_ctrl: directed vector and sequence bench for led_mode_ctrl
module tb_led_mode_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] leds;
  logic [1:0] mode;
  logic       step_tick;
  int total = 0;
  int bad = 0;
  typedef struct {
    int         n;
    logic       en;
    logic       btn;
    logic [3:0] leds;
    logic [1:0] mode;
    logic       tick;
  } vec_t;
  vec_t tbl[$];
  led_mode_ctrl #(
    .NUM_LEDS(4), .STEP_CYCLES(8), .DEBOUNCE_CYCLES(4), .PWM_BITS(3), .BREATH_DIV(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_mode  (btn_mode),
    .enable    (enable),
    .leds      (leds),
    .mode      (mode),
    .step_tick (step_tick)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask
  function automatic vec_t mk(input int n, input logic en, input logic btn, input logic [3:0] l,
                              input logic [1:0] m, input logic t);
    vec_t v;
    v.n = n; v.en = en; v.btn = btn; v.leds = l; v.mode = m; v.tick = t;
    return v;
  endfunction
  function automatic int tri_duty(input int n);
    int m;
    m = n % 14;
    return (m <= 7) ? m : 14 - m;
  endfunction
  task automatic press(input int m0, input int m1, input string nm);
    btn_mode = 1'b1;
    step(6);
    chk({nm, "_hold"}, int'(mode), m0);
    step(1);
    chk({nm, "_adv"}, int'(mode), m1);
    btn_mode = 1'b0;
    step(8);
  endtask
  initial begin
    int quiet;
    int moved;
    tbl.push_back(mk(1,  1, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(6,  1, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(1,  1, 0, 4'b0001, 1, 1));
    tbl.push_back(mk(1,  1, 0, 4'b0010, 1, 0));
    tbl.push_back(mk(7,  1, 0, 4'b0010, 1, 1));
    tbl.push_back(mk(1,  1, 0, 4'b0100, 1, 0));
    tbl.push_back(mk(8,  1, 0, 4'b1000, 1, 0));
    tbl.push_back(mk(8,  1, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(20, 1, 0, 4'b0100, 1, 0));
    tbl.push_back(mk(1,  0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(3,  0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(1,  1, 0, 4'b0100, 1, 0));
    tbl.push_back(mk(1,  1, 0, 4'b0100, 1, 0));
    tbl.push_back(mk(1,  1, 0, 4'b0100, 1, 1));
    tbl.push_back(mk(1,  1, 0, 4'b1000, 1, 0));
    tbl.push_back(mk(6,  1, 1, 4'b1000, 1, 0));
    tbl.push_back(mk(1,  1, 1, 4'b1000, 2, 0));
    tbl.push_back(mk(1,  1, 1, 4'b0000, 2, 0));
    tbl.push_back(mk(7,  1, 1, 4'b0000, 2, 1));
    tbl.push_back(mk(1,  1, 1, 4'b1111, 2, 0));
    tbl.push_back(mk(4,  1, 1, 4'b1111, 2, 0));
    tbl.push_back(mk(3,  1, 0, 4'b1111, 2, 1));
    tbl.push_back(mk(1,  1, 0, 4'b0000, 2, 0));
    tbl.push_back(mk(7,  1, 0, 4'b0000, 2, 1));
    tbl.push_back(mk(1,  1, 0, 4'b1111, 2, 0));
    step(3);
    chk("reset_leds", int'(leds), 0);
    chk("reset_mode", int'(mode), 1);
    chk("reset_tick", int'(step_tick), 0);
    rst = 1'b0;
    foreach (tbl[i]) begin
      enable   = tbl[i].en;
      btn_mode = tbl[i].btn;
      step(tbl[i].n);
      chk($sformatf("row%0d_leds", i), int'(leds), int'(tbl[i].leds));
      chk($sformatf("row%0d_mode", i), int'(mode), int'(tbl[i].mode));
      chk($sformatf("row%0d_tick", i), int'(step_tick), int'(tbl[i].tick));
    end
    moved = 0;
    for (int i = 0; i < 4; i++) begin
      btn_mode = (i % 2 == 0);
      step(1);
      moved += int'(mode != 2'd2);
      step(1);
      moved += int'(mode != 2'd2);
    end
    btn_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      moved += int'(mode != 2'd2);
    end
    chk("bounce_hold", moved, 0);
    step(1);
    chk("bounce_adv", int'(mode), 3);
    for (int k = 1; k <= 64; k++) begin
      step(1);
      chk($sformatf("breathe_leds%0d", k), int'(leds), (((k - 1) % 8) < tri_duty((k - 1) / 2)) ? 15 : 0);
      chk($sformatf("breathe_tick%0d", k), int'(step_tick), (k % 8 == 0) ? 1 : 0);
    end
    btn_mode = 1'b0;
    step(8);
    press(3, 0, "off");
    quiet = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      quiet += int'(leds != 4'b0000) + int'(step_tick);
    end
    chk("off_quiet", quiet, 0);
    chk("off_mode", int'(mode), 0);
    btn_mode = 1'b1;
    step(7);
    chk("mq_adv", int'(mode), 1);
    step(1);
    chk("mq_entry_leds", int'(leds), 1);
    step(6);
    chk("mq_entry_notick", int'(step_tick), 0);
    step(1);
    chk("mq_entry_tick", int'(step_tick), 1);
    btn_mode = 1'b0;
    step(8);
    press(1, 2, "blink");
    btn_mode = 1'b1;
    step(4);
    rst = 1'b1;
    #1;
    chk("rst_mode", int'(mode), 1);
    chk("rst_leds", int'(leds), 0);
    chk("rst_tick", int'(step_tick), 0);
    btn_mode = 1'b0;
    step(2);
    rst = 1'b0;
    step(12);
    chk("rst_no_adv", int'(mode), 1);
    chk("rst_restart_leds", int'(leds), 2);
    rst = 1'b1;
    btn_mode = 1'b1;
    step(3);
    rst = 1'b0;
    step(6);
    chk("held_rst_wait", int'(mode), 1);
    step(1);
    chk("held_rst_adv", int'(mode), 2);
    step(13);
    chk("held_rst_once", int'(mode), 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
